// File: rtl/l2_mem_responder.sv
`default_nettype none
// ============================================================================
// Module   : l2_mem_responder
// Purpose  : Backing-store responder for the L1 miss/write path. It accepts one
//            single-word read or write request at a time and services it after
//            a fixed LATENCY. The result comes back on a valid/ready response
//            channel. It stands in for the next memory level.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk         in   1          system clock, rising edge
//   rst         in   1          synchronous active-high reset
//   req_valid   in   1          initiator presents a request
//   req_ready   out  1          responder can accept a request this cycle
//   req_wr_en   in   1          1 = write, 0 = read
//   req_addr    in   WORD_SIZE  word address
//   req_data    in   WORD_SIZE  write data (ignored for reads)
//   resp_valid  out  1          response available
//   resp_ready  in   1          initiator consumes the response this cycle
//   resp_data   out  WORD_SIZE  read data, or echoed write data
//   resp_wr     out  1          response belongs to a write
//   resp_err    out  1          request address was out of range
// ============================================================================
module l2_mem_responder #(
    parameter int WORD_SIZE      = 32,
    parameter int MEM_DEPTH_LOG2 = 8,
    parameter int LATENCY        = 3     // legal range 1..15
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic                 req_wr_en,
    input  logic [WORD_SIZE-1:0] req_addr,
    input  logic [WORD_SIZE-1:0] req_data,
    output logic                 resp_valid,
    input  logic                 resp_ready,
    output logic [WORD_SIZE-1:0] resp_data,
    output logic                 resp_wr,
    output logic                 resp_err
);

    localparam int c_DEPTH = 2 ** MEM_DEPTH_LOG2;
    // LATENCY=1 would give a zero-width counter; keep at least one bit.
    localparam int c_CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_LOAD = c_CNT_W'(LATENCY - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t                    r_state;
    state_t                    w_state_next;
    logic [c_CNT_W-1:0]        r_cnt;

    // Request captured at acceptance; later changes on req_* are ignored.
    logic                      r_wr_en;
    logic [WORD_SIZE-1:0]      r_addr;
    logic [WORD_SIZE-1:0]      r_data;

    logic                      r_resp_wr;
    logic                      r_resp_err;
    logic [WORD_SIZE-1:0]      r_resp_data;

    // Storage models DRAM: zero at power-up and untouched by rst.
    logic [WORD_SIZE-1:0]      r_mem [c_DEPTH] = '{default: '0};

    logic                      w_accept;
    logic                      w_done;
    logic                      w_out_of_range;
    logic [MEM_DEPTH_LOG2-1:0] w_index;

    assign w_index        = r_addr[MEM_DEPTH_LOG2-1:0];
    assign w_out_of_range = |r_addr[WORD_SIZE-1:MEM_DEPTH_LOG2];

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state and handshake outputs
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        req_ready    = 1'b0;
        resp_valid   = 1'b0;
        w_accept     = 1'b0;
        w_done       = 1'b0;
        case (r_state)
            S_IDLE: begin
                req_ready = !rst;
                if (req_valid && !rst) begin
                    w_accept     = 1'b1;
                    w_state_next = S_WAIT;
                end
            end
            S_WAIT: begin
                // rst wins over the final WAIT edge so an aborted write
                // never reaches the array.
                if ((r_cnt == '0) && !rst) begin
                    w_done       = 1'b1;
                    w_state_next = S_RESP;
                end
            end
            S_RESP: begin
                resp_valid = 1'b1;
                if (resp_ready) begin
                    w_state_next = S_IDLE;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Request capture, latency counter and response registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt       <= '0;
            r_wr_en     <= 1'b0;
            r_addr      <= '0;
            r_data      <= '0;
            r_resp_wr   <= 1'b0;
            r_resp_err  <= 1'b0;
            r_resp_data <= '0;
        end else begin
            if (w_accept) begin
                r_wr_en <= req_wr_en;
                r_addr  <= req_addr;
                r_data  <= req_data;
                r_cnt   <= c_CNT_LOAD;
            end else if ((r_state == S_WAIT) && !w_done) begin
                r_cnt <= r_cnt - c_CNT_W'(1);
            end

            // Response fields only change on the completing edge, so they
            // stay stable for as long as the initiator back-pressures.
            if (w_done) begin
                r_resp_wr  <= r_wr_en;
                r_resp_err <= w_out_of_range;
                if (w_out_of_range) begin
                    r_resp_data <= '0;
                end else if (r_wr_en) begin
                    r_resp_data <= r_data;
                end else begin
                    r_resp_data <= r_mem[w_index];
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Array write port; commits on the completing WAIT edge
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (w_done && r_wr_en && !w_out_of_range) begin
            r_mem[w_index] <= r_data;
        end
    end

    assign resp_data = r_resp_data;
    assign resp_wr   = r_resp_wr;
    assign resp_err  = r_resp_err;

endmodule
`default_nettype wire

// File: tb/tb_l2_mem_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_l2_mem_responder
// Purpose  : Self-checking bench for l2_mem_responder. One instance uses the
//            default LATENCY=3 and a second uses LATENCY=1.
// Revision : 1.0 - initial release
// ============================================================================
module tb_l2_mem_responder;

    localparam int c_LAT = 3;

    logic        clk = 1'b0;
    logic        rst;

    // LATENCY=3 instance
    logic        req_valid, req_ready, req_wr_en;
    logic [31:0] req_addr, req_data;
    logic        resp_valid, resp_ready, resp_wr, resp_err;
    logic [31:0] resp_data;

    // LATENCY=1 instance
    logic        req_valid1, req_ready1, req_wr_en1;
    logic [31:0] req_addr1, req_data1;
    logic        resp_valid1, resp_ready1, resp_wr1, resp_err1;
    logic [31:0] resp_data1;

    int n_vec = 0;
    int n_err = 0;

    // Reference memory: plain array, updated by request rules only.
    logic [31:0] ref_mem [256];

    always #5 clk = ~clk;

    l2_mem_responder #(.WORD_SIZE(32), .MEM_DEPTH_LOG2(8), .LATENCY(c_LAT)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_wr_en(req_wr_en),
        .req_addr(req_addr), .req_data(req_data),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_data(resp_data), .resp_wr(resp_wr), .resp_err(resp_err)
    );

    l2_mem_responder #(.WORD_SIZE(32), .MEM_DEPTH_LOG2(8), .LATENCY(1)) dut_l1 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid1), .req_ready(req_ready1), .req_wr_en(req_wr_en1),
        .req_addr(req_addr1), .req_data(req_data1),
        .resp_valid(resp_valid1), .resp_ready(resp_ready1),
        .resp_data(resp_data1), .resp_wr(resp_wr1), .resp_err(resp_err1)
    );

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] data;
        int          hold;
        logic [31:0] exp_data;
        logic        exp_wr;
        logic        exp_err;
    } vec_t;

    vec_t tbl[10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Out-of-range means any address at or above the array size.
    function automatic void model(input logic wr, input logic [31:0] addr,
                                  input logic [31:0] data, output logic [31:0] ed,
                                  output logic ew, output logic ee);
        ew = wr;
        if (addr >= 32'd256) begin
            ee = 1'b1;
            ed = 32'h0;
        end else begin
            ee = 1'b0;
            if (wr) begin
                ref_mem[addr] = data;
                ed = data;
            end else begin
                ed = ref_mem[addr];
            end
        end
    endfunction

    // One complete transaction on the LATENCY=3 instance, including optional
    // back-pressure and a stray request presented while busy.
    task automatic run_txn(input logic wr, input logic [31:0] addr, input logic [31:0] data,
                           input int hold, input logic [31:0] exp_data,
                           input logic exp_wr, input logic exp_err);
        int guard;
        int lat;
        @(negedge clk);
        guard = 0;
        while (!req_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        chk("req_ready_wait", 32'(req_ready), 32'd1);
        req_valid = 1'b1;
        req_wr_en = wr;
        req_addr  = addr;
        req_data  = data;
        @(posedge clk);
        #1;
        // Scramble the request after acceptance; it must have no effect.
        req_valid  = 1'b0;
        req_wr_en  = ~wr;
        req_addr   = ~addr;
        req_data   = ~data;
        resp_ready = 1'($urandom_range(0, 1));
        lat = 0;
        while (!resp_valid && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
            if (!resp_valid) resp_ready = 1'($urandom_range(0, 1));
        end
        resp_ready = 1'b0;
        chk("latency", 32'(lat), 32'(c_LAT));
        chk("resp_data", resp_data, exp_data);
        chk("resp_wr", 32'(resp_wr), 32'(exp_wr));
        chk("resp_err", 32'(resp_err), 32'(exp_err));
        for (int i = 0; i < hold; i++) begin
            req_valid = 1'b1;
            req_wr_en = 1'b1;
            req_addr  = addr + 32'd1;
            req_data  = 32'hBAD0_0000 | 32'(i);
            @(posedge clk);
            #1;
            chk("hold_valid", 32'(resp_valid), 32'd1);
            chk("hold_data", resp_data, exp_data);
            chk("hold_wr", 32'(resp_wr), 32'(exp_wr));
            chk("hold_err", 32'(resp_err), 32'(exp_err));
            chk("hold_req_ready", 32'(req_ready), 32'd0);
        end
        req_valid  = 1'b0;
        resp_ready = 1'b1;
        @(posedge clk);
        #1;
        resp_ready = 1'b0;
        chk("post_hs_valid", 32'(resp_valid), 32'd0);
        chk("post_hs_ready", 32'(req_ready), 32'd1);
    endtask

    initial begin
        logic [31:0] ed;
        logic        ew, ee;
        logic [31:0] a;

        for (int i = 0; i < 256; i++) ref_mem[i] = 32'h0;

        tbl[0] = '{1'b1, 32'h0000_0005, 32'hDEAD_BEEF, 0, 32'hDEAD_BEEF, 1'b1, 1'b0};
        tbl[1] = '{1'b0, 32'h0000_0005, 32'h0,         5, 32'hDEAD_BEEF, 1'b0, 1'b0};
        tbl[2] = '{1'b0, 32'h0000_0006, 32'h0,         0, 32'h0000_0000, 1'b0, 1'b0};
        tbl[3] = '{1'b1, 32'h0000_0100, 32'h0000_1234, 0, 32'h0000_0000, 1'b1, 1'b1};
        tbl[4] = '{1'b0, 32'h0000_0000, 32'h0,         0, 32'h0000_0000, 1'b0, 1'b0};
        tbl[5] = '{1'b1, 32'h0000_00FF, 32'h0BAD_F00D, 1, 32'h0BAD_F00D, 1'b1, 1'b0};
        tbl[6] = '{1'b0, 32'h0000_00FF, 32'h0,         0, 32'h0BAD_F00D, 1'b0, 1'b0};
        tbl[7] = '{1'b0, 32'h8000_0005, 32'h0,         2, 32'h0000_0000, 1'b0, 1'b1};
        tbl[8] = '{1'b1, 32'h0000_0005, 32'h1111_2222, 0, 32'h1111_2222, 1'b1, 1'b0};
        tbl[9] = '{1'b0, 32'h0000_0005, 32'h0,         0, 32'h1111_2222, 1'b0, 1'b0};

        rst = 1'b1;
        req_valid = 1'b0; req_wr_en = 1'b0; req_addr = '0; req_data = '0; resp_ready = 1'b0;
        req_valid1 = 1'b0; req_wr_en1 = 1'b0; req_addr1 = '0; req_data1 = '0; resp_ready1 = 1'b0;

        // Reset and idle
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("rst_req_ready", 32'(req_ready), 32'd0);
            chk("rst_resp_valid", 32'(resp_valid), 32'd0);
            chk("rst_resp_data", resp_data, 32'd0);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("release_req_ready", 32'(req_ready), 32'd1);

        // Directed table
        for (int i = 0; i < 10; i++) begin
            run_txn(tbl[i].wr, tbl[i].addr, tbl[i].data, tbl[i].hold,
                    tbl[i].exp_data, tbl[i].exp_wr, tbl[i].exp_err);
            model(tbl[i].wr, tbl[i].addr, tbl[i].data, ed, ew, ee);
        end

        // Reset while a write to 0x0A waits: the write must be dropped.
        @(negedge clk);
        req_valid = 1'b1; req_wr_en = 1'b1; req_addr = 32'h0A; req_data = 32'h55AA_55AA;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("midrst_req_ready", 32'(req_ready), 32'd0);
            chk("midrst_resp_valid", 32'(resp_valid), 32'd0);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("aborted_resp_valid", 32'(resp_valid), 32'd0);
        end
        run_txn(1'b0, 32'h0A, 32'h0, 0, 32'h0, 1'b0, 1'b0);

        // Randomised traffic against the reference model
        for (int n = 0; n < 60; n++) begin
            logic        wr;
            logic [31:0] d;
            int          r;
            wr = 1'($urandom_range(0, 1));
            d  = $urandom;
            r  = $urandom_range(0, 9);
            if (r == 0)      a = $urandom | 32'h0000_0100;
            else if (r == 1) a = 32'h0000_00FF;
            else             a = 32'($urandom_range(0, 15));
            model(wr, a, d, ed, ew, ee);
            run_txn(wr, a, d, $urandom_range(0, 3), ed, ew, ee);
        end

        // LATENCY=1: IDLE, WAIT, RESP repeating with requests always offered
        // and resp_ready tied high. First a write to 7, then reads of 7.
        @(negedge clk);
        req_valid1 = 1'b1; req_wr_en1 = 1'b1; req_addr1 = 32'h7; req_data1 = 32'hA5A5_0F0F;
        resp_ready1 = 1'b1;
        for (int i = 0; i < 9; i++) begin
            chk("l1_req_ready", 32'(req_ready1), 32'((i % 3) == 0));
            chk("l1_resp_valid", 32'(resp_valid1), 32'((i % 3) == 2));
            if ((i % 3) == 2) begin
                chk("l1_resp_data", resp_data1, 32'hA5A5_0F0F);
                chk("l1_resp_wr", 32'(resp_wr1), 32'(i == 2));
                chk("l1_resp_err", 32'(resp_err1), 32'd0);
            end
            @(posedge clk);
            #1;
            if (i == 0) req_wr_en1 = 1'b0;
            @(negedge clk);
        end
        req_valid1 = 1'b0;
        resp_ready1 = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
